systolic_mac_array: RTL and testbench

Output-stationary SIZE×SIZE systolic multiply-accumulate array computing C = A·B. It sits directly downstream of the matrix skew stage. It consumes one skewed row-edge vector for A and one skewed column-edge vector for B per beat, for 2·SIZE−1 beats. It then drains internally and presents the full result matrix under a valid/ready handshake.

---
 rtl/systolic_mac_array.sv | 139 +++++++++++++
 tb/tb_systolic_mac_array.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_array.sv
// Output-stationary SIZE x SIZE systolic MAC array computing C = A*B from skewed edge beats.
// Define SA_SIGNED_EN for two's-complement signed operands; unsigned arithmetic otherwise.
module systolic_mac_array #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SIZE  = 3,
  parameter int unsigned ACCW  = 2*WIDTH + $clog2(SIZE)
) (
  input  logic                       clock,
  input  logic                       nreset,
  input  logic                       start,
  input  logic [SIZE*WIDTH-1:0]      a_in,
  input  logic [SIZE*WIDTH-1:0]      b_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       busy,
  output logic [SIZE*SIZE*ACCW-1:0]  result,
  output logic                       result_valid,
  input  logic                       result_ready
);

  localparam int unsigned CW = $clog2(3*SIZE);
  localparam logic [CW-1:0] LAST_BEAT = CW'(2*SIZE - 2);
  localparam logic [CW-1:0] LAST_ADV  = CW'(3*SIZE - 3);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            advance;
  logic            clear;
  logic            drain;

  assign drain   = (state == DRAIN);
  assign advance = ((state == RUN) && in_valid) || drain;
  assign clear   = (state == IDLE) && start;

  // Control: beat/drain counting and registered handshake outputs
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      cnt          <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (in_valid) begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST_BEAT) begin
              in_ready <= 1'b0;
              if (SIZE == 1) begin
                state        <= DONE;
                busy         <= 1'b0;
                result_valid <= 1'b1;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST_ADV) begin
            state        <= DONE;
            busy         <= 1'b0;
            result_valid <= 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Processing element grid; edge lanes take zeros while draining
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] b_reg;
      logic [ACCW-1:0]  acc;
      logic [WIDTH-1:0] a_left;
      logic [WIDTH-1:0] b_top;
      logic [ACCW-1:0]  prod;

      if (gj == 0) begin : g_a_edge
        assign a_left = drain ? '0 : a_in[gi*WIDTH +: WIDTH];
      end else begin : g_a_inner
        assign a_left = g_row[gi].g_col[gj-1].a_reg;
      end

      if (gi == 0) begin : g_b_edge
        assign b_top = drain ? '0 : b_in[gj*WIDTH +: WIDTH];
      end else begin : g_b_inner
        assign b_top = g_row[gi-1].g_col[gj].b_reg;
      end

`ifdef SA_SIGNED_EN
      assign prod = ACCW'($signed(a_left)) * ACCW'($signed(b_top));
`else
      assign prod = ACCW'(a_left) * ACCW'(b_top);
`endif

      always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
          a_reg <= '0;
          b_reg <= '0;
          acc   <= '0;
        end else if (clear) begin
          a_reg <= '0;
          b_reg <= '0;
          acc   <= '0;
        end else if (advance) begin
          a_reg <= a_left;
          b_reg <= b_top;
          acc   <= acc + prod;
        end
      end

      assign result[(gi*SIZE + gj)*ACCW +: ACCW] = acc;
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Randomised self-checking bench for systolic_mac_array against a plain matrix-product model.
module tb_systolic_mac_array;

  localparam int unsigned S   = 3;
  localparam int unsigned W   = 4;
  localparam int unsigned AW  = 2*W + $clog2(S);
  localparam int unsigned AIW = S*W;

  logic              clock = 1'b0;
  logic              nreset;
  logic              start;
  logic [AIW-1:0]    a_in;
  logic [AIW-1:0]    b_in;
  logic              in_valid;
  logic              in_ready;
  logic              busy;
  logic [S*S*AW-1:0] result;
  logic              result_valid;
  logic              result_ready;

  int vectors    = 0;
  int miscompares = 0;

  logic [W-1:0]  ma   [S][S];
  logic [W-1:0]  mb   [S][S];
  logic [AW-1:0] expc [S][S];

  systolic_mac_array #(.WIDTH(W), .SIZE(S)) dut (
    .clock        (clock),
    .nreset       (nreset),
    .start        (start),
    .a_in         (a_in),
    .b_in         (b_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic int ev(input logic [W-1:0] x);
`ifdef SA_SIGNED_EN
    return int'($signed(x));
`else
    return int'(x);
`endif
  endfunction

  // Reference: C = A*B by direct summation, reduced to AW bits
  task automatic build_expected();
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        int s = 0;
        for (int k = 0; k < S; k++) s += ev(ma[i][k]) * ev(mb[k][j]);
        expc[i][j] = AW'(s);
      end
  endtask

  task automatic set_a_fixed();
    int vals [9] = '{1, 2, 3, 7, 6, 5, 8, 9, 4};
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) ma[i][j] = W'(vals[i*S + j]);
  endtask

  task automatic set_b_identity();
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) mb[i][j] = (i == j) ? W'(1) : W'(0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        ma[i][j] = W'($urandom);
        mb[i][j] = W'($urandom);
      end
  endtask

  task automatic drive_beat(input int t);
    for (int l = 0; l < S; l++) begin
      int k = t - l;
      a_in[l*W +: W] = (k >= 0 && k < S) ? ma[l][k] : W'(0);
      b_in[l*W +: W] = (k >= 0 && k < S) ? mb[k][l] : W'(0);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_result(input string name);
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        vectors++;
        if (result[(i*S + j)*AW +: AW] !== expc[i][j]) begin
          miscompares++;
          $display("FAIL %s C[%0d][%0d]: got %0d required %0d", name, i, j,
                   result[(i*S + j)*AW +: AW], expc[i][j]);
        end
      end
  endtask

  task automatic check_idle_outputs(input string name);
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s outputs: got in_ready=%b busy=%b result_valid=%b required 0 0 0",
               name, in_ready, busy, result_valid);
    end
  endtask

  // Start, feed skewed beats with nstall scattered bubbles, then wait for result_valid
  task automatic run_product(input string name, input int nstall);
    logic [2*S-1:0] stall_mask;
    int placed;
    int cyc;
    int t;
    build_expected();
    stall_mask = '0;
    placed = 0;
    while (placed < nstall) begin
      int p = int'($urandom_range(2*S-2, 1));
      if (!stall_mask[p]) begin
        stall_mask[p] = 1'b1;
        placed++;
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    t = 0;
    while (t < 2*S-1) begin
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s run_ready beat %0d: got in_ready=%b busy=%b required 1 1",
                 name, t, in_ready, busy);
      end
      if (stall_mask[t]) begin
        stall_mask[t] = 1'b0;
        in_valid = 1'b0;
        a_in = AIW'($urandom);
        b_in = AIW'($urandom);
      end else begin
        in_valid = 1'b1;
        drive_beat(t);
        t++;
      end
      step();
      cyc++;
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s drain_ready: got in_ready=%b required 0", name, in_ready);
    end
    while (!result_valid && cyc < 40) begin
      in_valid = 1'($urandom);
      a_in = AIW'($urandom);
      b_in = AIW'($urandom);
      step();
      cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (cyc != 3*S-1+nstall) begin
      miscompares++;
      $display("FAIL %s latency: got cycle %0d required %0d", name, cyc, 3*S-1+nstall);
    end
    check_result(name);
  endtask

  task automatic handshake(input string name);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check_idle_outputs({name, "_after_handshake"});
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    #2;
    check_idle_outputs("reset");
    vectors++;
    if (result !== '0) begin
      miscompares++;
      $display("FAIL reset result: got %h required 0", result);
    end
    step();
    nreset = 1'b1;
    step();
  endtask

  task automatic test_identity();
    set_a_fixed();
    set_b_identity();
    run_product("identity", 0);
    handshake("identity");
  endtask

  task automatic test_all_max();
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        ma[i][j] = W'(15);
        mb[i][j] = W'(15);
      end
    run_product("all_max", 0);
`ifndef SA_SIGNED_EN
    vectors++;
    if (result[(S*S-1)*AW +: AW] !== 10'h2A3) begin
      miscompares++;
      $display("FAIL all_max C[2][2]: got %h required 2a3", result[(S*S-1)*AW +: AW]);
    end
`endif
    handshake("all_max");
  endtask

  task automatic test_stalls();
    set_a_fixed();
    set_b_identity();
    run_product("stalls", 3);
    handshake("stalls");
  endtask

  task automatic test_done_hold();
    fill_random();
    run_product("done_hold", 0);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      step();
      vectors++;
      if (result_valid !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL done_hold cycle %0d: got result_valid=%b busy=%b required 1 0",
                 c, result_valid, busy);
      end
      check_result("done_hold");
    end
    start = 1'b0;
    handshake("done_hold");
    step();
    check_idle_outputs("done_hold_idle");
  endtask

  task automatic test_abort();
    set_a_fixed();
    set_b_identity();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 2; t++) begin
      in_valid = 1'b1;
      drive_beat(t);
      step();
    end
    in_valid = 1'b1;
    drive_beat(2);
    #2;
    nreset = 1'b0;
    #1;
    check_idle_outputs("abort");
    vectors++;
    if (result !== '0) begin
      miscompares++;
      $display("FAIL abort result: got %h required 0", result);
    end
    in_valid = 1'b0;
    @(negedge clock);
    nreset = 1'b1;
    step();
    check_idle_outputs("abort_released");
    run_product("after_abort", 0);
    handshake("after_abort");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      fill_random();
      run_product("random", int'($urandom_range(4, 0)));
      handshake("random");
    end
  endtask

`ifdef SA_SIGNED_EN
  task automatic test_signed();
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        ma[i][j] = W'(15);
        mb[i][j] = W'(1);
      end
    run_product("signed", 0);
    vectors++;
    if (result[0 +: AW] !== 10'h3FD) begin
      miscompares++;
      $display("FAIL signed C[0][0]: got %h required 3fd", result[0 +: AW]);
    end
    handshake("signed");
  endtask
`endif

  initial begin
    nreset       = 1'b0;
    start        = 1'b0;
    in_valid     = 1'b0;
    result_ready = 1'b0;
    a_in         = '0;
    b_in         = '0;
    test_reset();
    test_identity();
    test_all_max();
    test_stalls();
    test_done_hold();
    test_abort();
    test_back_to_back();
`ifdef SA_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
